// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/data arbiter in front of a single-port memory
module mem_arbiter #(
    parameter int INSTR_SIZE   = 12,
    parameter int DATA_SIZE    = 8,
    parameter int ADDR_SIZE    = 5,
    parameter int PROGRAM_SIZE = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_SIZE-1:0]  if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [INSTR_SIZE-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_SIZE-1:0]  d_addr,
    input  logic [DATA_SIZE-1:0]  d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_SIZE-1:0]  d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_SIZE-1:0]  mem_addr,
    output logic [INSTR_SIZE-1:0] mem_wdata,
    input  logic [INSTR_SIZE-1:0] mem_rdata,
    output logic                  out_of_bounds
);

    typedef enum logic {S_IDLE, S_RESP} state_t;

    localparam logic [ADDR_SIZE:0] PROG_LIM = (ADDR_SIZE+1)'(PROGRAM_SIZE);

    state_t r_state;
    state_t w_state_nxt;
    logic   r_last_data;
    logic   r_win_data;
    logic   r_store;
    logic   r_fetch_oob;
    logic   r_oob;
    logic   w_grant;
    logic   w_pick_data;
    logic   w_oob_hit;
    logic   w_fetch_legal;
    logic   w_store_legal;

    assign w_fetch_legal = ({1'b0, if_addr} < PROG_LIM);
    assign w_store_legal = ({1'b0, d_addr} >= PROG_LIM);
    assign out_of_bounds = r_oob;

    // Everything is gated by rst_n so outputs drop the instant reset asserts.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_pick_data = 1'b0;
        w_oob_hit   = 1'b0;
        if_gnt      = 1'b0;
        if_rvalid   = 1'b0;
        if_rdata    = '0;
        d_gnt       = 1'b0;
        d_rvalid    = 1'b0;
        d_rdata     = '0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (rst_n) begin
            case (r_state)
                S_IDLE: begin
                    if (if_req || d_req) begin
                        w_grant     = 1'b1;
                        w_pick_data = d_req && (!if_req || !r_last_data);
                        w_state_nxt = S_RESP;
                        if (w_pick_data) begin
                            d_gnt = 1'b1;
                            if (!d_we) begin
                                mem_en   = 1'b1;
                                mem_addr = d_addr;
                            end else if (w_store_legal) begin
                                mem_en    = 1'b1;
                                mem_we    = 1'b1;
                                mem_addr  = d_addr;
                                mem_wdata = INSTR_SIZE'(d_wdata);
                            end else begin
                                w_oob_hit = 1'b1;
                            end
                        end else begin
                            if_gnt = 1'b1;
                            if (w_fetch_legal) begin
                                mem_en   = 1'b1;
                                mem_addr = if_addr;
                            end else begin
                                w_oob_hit = 1'b1;
                            end
                        end
                    end
                end
                S_RESP: begin
                    w_state_nxt = S_IDLE;
                    if (r_win_data) begin
                        d_rvalid = 1'b1;
                        d_rdata  = r_store ? '0 : mem_rdata[DATA_SIZE-1:0];
                    end else begin
                        if_rvalid = 1'b1;
                        if_rdata  = r_fetch_oob ? '0 : mem_rdata;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_last_data <= 1'b1;
            r_win_data  <= 1'b0;
            r_store     <= 1'b0;
            r_fetch_oob <= 1'b0;
            r_oob       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_last_data <= w_pick_data;
                r_win_data  <= w_pick_data;
                r_store     <= w_pick_data && d_we;
                r_fetch_oob <= !w_pick_data && !w_fetch_legal;
            end
            if (w_oob_hit) begin
                r_oob <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and random checks of mem_arbiter against a transaction model
module tb_mem_arbiter;

    localparam int PSIZE = 16;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [4:0]  if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [11:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [4:0]  d_addr;
    logic [7:0]  d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [7:0]  d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic        out_of_bounds;

    logic [11:0] mem [32];
    logic [11:0] ref_mem [32];

    int n_total = 0;
    int n_bad   = 0;

    bit         m_resp;
    bit         m_last_data;
    bit         m_oob;
    bit         m_win_data;
    bit         m_store;
    logic [4:0] m_addr;
    bit         e_fg;
    bit         e_dg;

    mem_arbiter #(.INSTR_SIZE(12), .DATA_SIZE(8), .ADDR_SIZE(5), .PROGRAM_SIZE(PSIZE)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .out_of_bounds(out_of_bounds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of checking: outputs are compared against what the transaction rules predict.
    task automatic step(input string tag);
        bit          pick_data;
        bit          viol;
        logic        e_en;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [11:0] e_wd;
        #1;
        e_fg = 1'b0;
        e_dg = 1'b0;
        if (!rst_n) begin
            chk({tag, ".rst_gnt"},    {if_gnt, d_gnt}, 0);
            chk({tag, ".rst_rvalid"}, {if_rvalid, d_rvalid}, 0);
            chk({tag, ".rst_rdata"},  {if_rdata, d_rdata}, 0);
            chk({tag, ".rst_mem"},    {mem_en, mem_we, mem_addr, mem_wdata}, 0);
            chk({tag, ".rst_oob"},    out_of_bounds, 0);
            m_resp      = 1'b0;
            m_last_data = 1'b1;
            m_oob       = 1'b0;
        end else if (m_resp) begin
            chk({tag, ".resp_gnt"}, {if_gnt, d_gnt}, 0);
            chk({tag, ".resp_mem"}, {mem_en, mem_we}, 0);
            chk({tag, ".if_rvalid"}, if_rvalid, !m_win_data);
            chk({tag, ".d_rvalid"},  d_rvalid,  m_win_data);
            if (m_win_data) begin
                chk({tag, ".d_rdata"},  d_rdata, m_store ? 8'h00 : ref_mem[m_addr][7:0]);
                chk({tag, ".if_rdata0"}, if_rdata, 0);
            end else begin
                chk({tag, ".if_rdata"}, if_rdata, (m_addr >= PSIZE) ? 12'h000 : ref_mem[m_addr]);
                chk({tag, ".d_rdata0"}, d_rdata, 0);
            end
            chk({tag, ".oob"}, out_of_bounds, m_oob);
            m_resp = 1'b0;
        end else begin
            chk({tag, ".idle_rvalid"}, {if_rvalid, d_rvalid}, 0);
            chk({tag, ".idle_rdata"},  {if_rdata, d_rdata}, 0);
            chk({tag, ".oob"}, out_of_bounds, m_oob);
            e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
            if (if_req || d_req) begin
                if (if_req && d_req) pick_data = !m_last_data;
                else                 pick_data = d_req;
                e_dg = pick_data;
                e_fg = !pick_data;
                if (pick_data) begin
                    viol = d_we && (d_addr < PSIZE);
                    if (!viol) begin
                        e_en = 1'b1; e_we = d_we; e_addr = d_addr;
                        if (d_we) begin
                            e_wd = {4'h0, d_wdata};
                            ref_mem[d_addr] = e_wd;
                        end
                    end
                    m_addr  = d_addr;
                    m_store = d_we;
                end else begin
                    viol = (if_addr >= PSIZE);
                    if (!viol) begin
                        e_en = 1'b1; e_addr = if_addr;
                    end
                    m_addr  = if_addr;
                    m_store = 1'b0;
                end
                if (viol) m_oob = 1'b1;
                m_resp      = 1'b1;
                m_win_data  = pick_data;
                m_last_data = pick_data;
            end
            chk({tag, ".if_gnt"}, if_gnt, e_fg);
            chk({tag, ".d_gnt"},  d_gnt,  e_dg);
            chk({tag, ".mem_en"}, mem_en, e_en);
            chk({tag, ".mem_we"}, mem_we, e_we);
            if (e_en) chk({tag, ".mem_addr"},  mem_addr,  e_addr);
            if (e_we) chk({tag, ".mem_wdata"}, mem_wdata, e_wd);
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            ref_mem[i] = 12'($urandom);
            if (i == 3) ref_mem[i] = 12'hA05;
            mem[i] <= ref_mem[i];
        end
        mem_rdata <= 12'h000;
        rst_n = 1'b0; if_req = 1'b1; if_addr = 5'd3; d_req = 1'b1; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        @(negedge clk);
        step("reset");
        if_req = 1'b0; d_req = 1'b0; rst_n = 1'b1;
        step("idle");

        if_req = 1'b1; if_addr = 5'd3;
        #1; chk("f3.gnt", {if_gnt, mem_en, mem_addr}, {1'b1, 1'b1, 5'd3});
        step("f3a");
        if_req = 1'b0;
        #1; chk("f3.rdata", {if_rvalid, if_rdata}, {1'b1, 12'hA05});
        step("f3b");

        rst_n = 1'b0; step("rst2"); rst_n = 1'b1;
        if_req = 1'b1; d_req = 1'b1; if_addr = 5'd5; d_we = 1'b0; d_addr = 5'd20;
        for (int i = 0; i < 8; i++) begin
            #1; chk("tie.gnt", {if_gnt, d_gnt}, {(i % 4) == 0, (i % 4) == 2});
            step("tie");
        end
        if_req = 1'b0; d_req = 1'b0;
        step("tie_end");

        d_req = 1'b1; d_we = 1'b1; d_addr = 5'd17; d_wdata = 8'h05;
        #1; chk("st17.mem", {mem_we, mem_wdata}, {1'b1, 12'h005});
        step("st17a");
        d_req = 1'b0;
        #1; chk("st17.ack", {d_rvalid, d_rdata}, {1'b1, 8'h00});
        step("st17b");
        d_req = 1'b1; d_we = 1'b0;
        step("ld17a");
        d_req = 1'b0;
        #1; chk("ld17.rdata", {d_rvalid, d_rdata, out_of_bounds}, {1'b1, 8'h05, 1'b0});
        step("ld17b");

        if_req = 1'b1; if_addr = 5'd20;
        #1; chk("f20.noen", {if_gnt, mem_en}, {1'b1, 1'b0});
        step("f20a");
        if_req = 1'b0;
        #1; chk("f20.resp", {if_rvalid, if_rdata, out_of_bounds}, {1'b1, 12'h000, 1'b1});
        step("f20b");
        d_req = 1'b1; d_we = 1'b1; d_addr = 5'd4; d_wdata = 8'hAA;
        #1; chk("st4.nowe", {d_gnt, mem_en, mem_we}, {1'b1, 1'b0, 1'b0});
        step("st4a");
        d_req = 1'b0;
        step("st4b");
        d_we = 1'b0; d_req = 1'b1;
        step("ld4a");
        d_req = 1'b0;
        step("ld4b");
        for (int i = 0; i < 10; i++) step("sticky");
        chk("sticky.oob", out_of_bounds, 1);

        d_req = 1'b1; d_we = 1'b0; d_addr = 5'd9;
        step("rr_a");
        rst_n = 1'b0;
        #1; chk("rr.zero", {d_rvalid, d_rdata, d_gnt, mem_en, out_of_bounds}, 0);
        step("rr_b");
        rst_n = 1'b1;
        #1; chk("rr.regrant", {d_gnt, d_rvalid, if_rvalid}, {1'b1, 1'b0, 1'b0});
        step("rr_c");
        d_req = 1'b0;
        #1; chk("rr.resp", d_rvalid, 1);
        step("rr_d");

        for (int c = 0; c < 400; c++) begin
            if (e_fg || !if_req) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = 5'($urandom);
            end
            if (e_dg || !d_req) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 5'($urandom);
                d_wdata = 8'($urandom);
            end
            step("rnd");
        end
        if_req = 1'b0; d_req = 1'b0;
        step("drain1");
        step("drain2");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
